// File: rtl/fleet_pkg.sv
// Shared constants for the invader fleet controller: state codes, invader
// count width/limit and a small helper used for counter sizing.
package fleet_pkg;

    localparam int ALIVE_W      = 6;
    localparam int MAX_INVADERS = 55;

    typedef logic [2:0] fleet_state_t;

    localparam fleet_state_t ST_IDLE      = 3'd0;
    localparam fleet_state_t ST_MARCH_R   = 3'd1;
    localparam fleet_state_t ST_DROP_TO_L = 3'd2;
    localparam fleet_state_t ST_MARCH_L   = 3'd3;
    localparam fleet_state_t ST_DROP_TO_R = 3'd4;
    localparam fleet_state_t ST_LANDED    = 3'd5;
    localparam fleet_state_t ST_CLEAR     = 3'd6;

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic logic is_march(input fleet_state_t s);
        return (s == ST_MARCH_R) || (s == ST_MARCH_L);
    endfunction

    function automatic logic is_drop(input fleet_state_t s);
        return (s == ST_DROP_TO_L) || (s == ST_DROP_TO_R);
    endfunction

endpackage

// File: rtl/fleet_step_timer.sv
// Frame counter with period compare; wrap is high in the cycle whose tick
// completes a period, and the counter returns to zero on that tick.
module fleet_step_timer #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         enable,
    input  logic         tick,
    input  logic [W-1:0] period,
    output logic         wrap
);

    logic [W-1:0] r_count;
    logic [W-1:0] w_last;

    assign w_last = period - W'(1);
    assign wrap   = enable && tick && (r_count == w_last);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (enable && tick) begin
            r_count <= wrap ? '0 : r_count + W'(1);
        end
    end

endmodule

// File: rtl/invader_fleet_ctrl.sv
// Invader fleet march/drop sequencer. Define FLEET_SPEEDUP_EN to make the
// march period shrink with the number of live invaders.
module invader_fleet_ctrl
    import fleet_pkg::*;
#(
    parameter int STEP_FRAMES_FIX = 30,
    parameter int STEP_FRAMES_MIN = 4,
    parameter int DROP_FRAMES     = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               startOfFrame,
    input  logic               gameStart,
    input  logic               pause,
    input  logic [ALIVE_W-1:0] aliveCount,
    input  logic               hitLeft,
    input  logic               hitRight,
    input  logic               hitBottom,
    output logic               stepPulse,
    output logic               dirRight,
    output logic               dropActive,
    output logic               landed,
    output logic               waveClear,
    output logic [2:0]         o_dbg_state
);

    // Counter must hold the longest period any build can select.
    localparam int PERIOD_MAX = imax(imax(STEP_FRAMES_FIX, DROP_FRAMES),
                                     STEP_FRAMES_MIN + (MAX_INVADERS >> 2));
    localparam int CNT_W      = $clog2(PERIOD_MAX + 1);

    fleet_state_t     r_state;
    fleet_state_t     w_next;
    logic             r_step;
    logic             r_dir;
    logic             w_in_play;
    logic             w_launch;
    logic             w_drop_entry;
    logic             w_step;
    logic             w_wrap;
    logic [CNT_W-1:0] w_step_period;
    logic [CNT_W-1:0] w_timer_period;

    assign w_in_play = is_march(r_state) || is_drop(r_state);

`ifdef FLEET_SPEEDUP_EN
    logic [CNT_W-1:0] r_period;
    logic [CNT_W-1:0] w_sampled_period;

    assign w_sampled_period = CNT_W'(STEP_FRAMES_MIN) + CNT_W'(aliveCount[ALIVE_W-1:2]);

    // Period is only re-sampled when the counter restarts, so a step in
    // flight always completes with the period it began with.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_period <= CNT_W'(STEP_FRAMES_MIN);
        end else if (w_launch || w_wrap) begin
            r_period <= w_sampled_period;
        end
    end

    assign w_step_period = r_period;
`else
    assign w_step_period = CNT_W'(STEP_FRAMES_FIX);
`endif

    assign w_timer_period = is_drop(r_state) ? CNT_W'(DROP_FRAMES) : w_step_period;

    fleet_step_timer #(
        .W (CNT_W)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (w_launch || w_drop_entry),
        .enable (w_in_play && !pause),
        .tick   (startOfFrame),
        .period (w_timer_period),
        .wrap   (w_wrap)
    );

    // Wave end beats landing, landing beats an edge hit, an edge hit beats a step.
    always_comb begin
        w_next       = r_state;
        w_launch     = 1'b0;
        w_drop_entry = 1'b0;
        w_step       = 1'b0;
        if (!pause) begin
            if (!w_in_play) begin
                if (gameStart) begin
                    w_next   = ST_MARCH_R;
                    w_launch = 1'b1;
                end
            end else if (aliveCount == '0) begin
                w_next = ST_CLEAR;
            end else if (hitBottom) begin
                w_next = ST_LANDED;
            end else begin
                case (r_state)
                    ST_MARCH_R: begin
                        if (hitRight) begin
                            w_next       = ST_DROP_TO_L;
                            w_drop_entry = 1'b1;
                        end else begin
                            w_step = w_wrap;
                        end
                    end
                    ST_MARCH_L: begin
                        if (hitLeft) begin
                            w_next       = ST_DROP_TO_R;
                            w_drop_entry = 1'b1;
                        end else begin
                            w_step = w_wrap;
                        end
                    end
                    ST_DROP_TO_L: if (w_wrap) w_next = ST_MARCH_L;
                    ST_DROP_TO_R: if (w_wrap) w_next = ST_MARCH_R;
                    default:      w_next = r_state;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_step  <= 1'b0;
            r_dir   <= 1'b1;
        end else begin
            r_state <= w_next;
            r_step  <= w_step;
            if ((w_next == ST_MARCH_R) || (w_next == ST_DROP_TO_R)) begin
                r_dir <= 1'b1;
            end else if ((w_next == ST_MARCH_L) || (w_next == ST_DROP_TO_L)) begin
                r_dir <= 1'b0;
            end
        end
    end

    assign stepPulse   = r_step;
    assign dirRight    = r_dir;
    assign dropActive  = is_drop(r_state);
    assign landed      = (r_state == ST_LANDED);
    assign waveClear   = (r_state == ST_CLEAR);
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_invader_fleet_ctrl.sv
// Bench for invader_fleet_ctrl: directed scenarios followed by random
// stimulus, all checked against a frame-counting reference model.
module tb_invader_fleet_ctrl;
    import fleet_pkg::*;

    localparam int P_FIX  = 30;
    localparam int P_MIN  = 4;
    localparam int P_DROP = 8;
    localparam int EXP_W  = 8;

    localparam int M_IDLE = 0, M_MR = 1, M_DL = 2, M_ML = 3, M_DR = 4, M_LANDED = 5, M_CLEAR = 6;

    logic               clk = 1'b0;
    logic               reset;
    logic               startOfFrame;
    logic               gameStart;
    logic               pause;
    logic [ALIVE_W-1:0] aliveCount;
    logic               hitLeft;
    logic               hitRight;
    logic               hitBottom;
    logic               stepPulse;
    logic               dirRight;
    logic               dropActive;
    logic               landed;
    logic               waveClear;
    logic [2:0]         o_dbg_state;

    int n_total = 0;
    int n_bad   = 0;

    int   m_st  = M_IDLE;
    int   m_cnt = 0;
    int   m_per = P_FIX;
    logic m_dir = 1'b1;
    logic m_step = 1'b0;

    logic [EXP_W-1:0] exp_q[$];

    invader_fleet_ctrl #(
        .STEP_FRAMES_FIX (P_FIX),
        .STEP_FRAMES_MIN (P_MIN),
        .DROP_FRAMES     (P_DROP)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .startOfFrame (startOfFrame),
        .gameStart    (gameStart),
        .pause        (pause),
        .aliveCount   (aliveCount),
        .hitLeft      (hitLeft),
        .hitRight     (hitRight),
        .hitBottom    (hitBottom),
        .stepPulse    (stepPulse),
        .dirRight     (dirRight),
        .dropActive   (dropActive),
        .landed       (landed),
        .waveClear    (waveClear),
        .o_dbg_state  (o_dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic int period_of(input int alive);
`ifdef FLEET_SPEEDUP_EN
        return P_MIN + alive / 4;
`else
        return P_FIX;
`endif
    endfunction

    function automatic logic [2:0] state_code(input int s);
        case (s)
            M_MR:     return ST_MARCH_R;
            M_DL:     return ST_DROP_TO_L;
            M_ML:     return ST_MARCH_L;
            M_DR:     return ST_DROP_TO_R;
            M_LANDED: return ST_LANDED;
            M_CLEAR:  return ST_CLEAR;
            default:  return ST_IDLE;
        endcase
    endfunction

    task automatic model_update();
        int   limit;
        logic in_drop;
        m_step = 1'b0;
        if (reset) begin
            m_st  = M_IDLE;
            m_cnt = 0;
            m_dir = 1'b1;
        end else if (pause) begin
            m_step = 1'b0;
        end else if (m_st == M_IDLE || m_st == M_LANDED || m_st == M_CLEAR) begin
            if (gameStart) begin
                m_st  = M_MR;
                m_cnt = 0;
                m_dir = 1'b1;
                m_per = period_of(int'(aliveCount));
            end
        end else if (aliveCount == 0) begin
            m_st = M_CLEAR;
        end else if (hitBottom) begin
            m_st = M_LANDED;
        end else if (m_st == M_MR && hitRight) begin
            m_st  = M_DL;
            m_cnt = 0;
            m_dir = 1'b0;
        end else if (m_st == M_ML && hitLeft) begin
            m_st  = M_DR;
            m_cnt = 0;
            m_dir = 1'b1;
        end else if (startOfFrame) begin
            limit = (m_st == M_DL || m_st == M_DR) ? P_DROP : m_per;
            m_cnt++;
            if (m_cnt >= limit) begin
                m_cnt = 0;
                m_per = period_of(int'(aliveCount));
                if (m_st == M_MR || m_st == M_ML) m_step = 1'b1;
                else if (m_st == M_DL)            m_st = M_ML;
                else                              m_st = M_MR;
            end
        end
        in_drop = (m_st == M_DL) || (m_st == M_DR);
        exp_q.push_back({state_code(m_st), m_step, m_dir, in_drop,
                         (m_st == M_LANDED), (m_st == M_CLEAR)});
    endtask

    // ---------------- scoreboard ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic cycle();
        logic [EXP_W-1:0] e;
        @(posedge clk);
        model_update();
        @(negedge clk);
        e = exp_q.pop_front();
        check("state",      o_dbg_state, e[7:5]);
        check("stepPulse",  stepPulse,   e[4]);
        check("dirRight",   dirRight,    e[3]);
        check("dropActive", dropActive,  e[2]);
        check("landed",     landed,      e[1]);
        check("waveClear",  waveClear,   e[0]);
    endtask

    task automatic frames(input int n, output int steps);
        steps = 0;
        for (int f = 0; f < n; f++) begin
            startOfFrame = 1'b1;
            cycle();
            steps += int'(stepPulse);
            startOfFrame = 1'b0;
            cycle();
            steps += int'(stepPulse);
            cycle();
            steps += int'(stepPulse);
        end
    endtask

    task automatic pulse_input(input int which);
        case (which)
            0: gameStart = 1'b1;
            1: hitRight  = 1'b1;
            2: hitLeft   = 1'b1;
            default: reset = 1'b1;
        endcase
        cycle();
        gameStart = 1'b0;
        hitRight  = 1'b0;
        hitLeft   = 1'b0;
        reset     = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int s;
        int gap;
        int alive_base;
        reset        = 1'b1;
        startOfFrame = 1'b0;
        gameStart    = 1'b0;
        pause        = 1'b0;
        aliveCount   = ALIVE_W'(MAX_INVADERS);
        hitLeft      = 1'b0;
        hitRight     = 1'b0;
        hitBottom    = 1'b0;

        cycle();
        cycle();
        check("rst_state", o_dbg_state, ST_IDLE);
        check("rst_dir",   dirRight,    1);
        reset = 1'b0;

        // Launch and march: two steps in 60 frames at the fixed period.
        pulse_input(0);
        check("launch_state", o_dbg_state, ST_MARCH_R);
        frames(60, s);
`ifndef FLEET_SPEEDUP_EN
        check("march_60_frames_steps", s, 2);
`endif

        // Right edge -> drop left for DROP_FRAMES frames -> march left.
        pulse_input(1);
        check("drop_l_active", dropActive, 1);
        check("drop_l_dir",    dirRight,   0);
        frames(P_DROP - 1, s);
        check("drop_l_still", o_dbg_state, ST_DROP_TO_L);
        frames(1, s);
        check("after_drop_state", o_dbg_state, ST_MARCH_L);
        check("after_drop_active", dropActive, 0);

        // Wave clear outranks landing when both arrive together.
        aliveCount = '0;
        hitBottom  = 1'b1;
        cycle();
        check("clear_flag",  waveClear, 1);
        check("clear_landed", landed,   0);
        aliveCount = ALIVE_W'(MAX_INVADERS);
        hitBottom  = 1'b0;
        cycle();
        check("clear_sticky", waveClear, 1);
        pulse_input(0);
        check("relaunch_state", o_dbg_state, ST_MARCH_R);
        check("relaunch_clear", waveClear,   0);

        // Pause mid-drop must freeze the drop count.
        pulse_input(1);
        frames(P_DROP, s);
        pulse_input(2);
        check("drop_r_state", o_dbg_state, ST_DROP_TO_R);
        frames(3, s);
        pause = 1'b1;
        frames(20, s);
        check("pause_no_step", s, 0);
        check("pause_state", o_dbg_state, ST_DROP_TO_R);
        pause = 1'b0;
        frames(P_DROP - 4, s);
        check("resume_still_drop", o_dbg_state, ST_DROP_TO_R);
        frames(1, s);
        check("resume_march_r", o_dbg_state, ST_MARCH_R);

        // Reset mid-drop, once while marching left-bound and once right-bound.
        pulse_input(1);
        frames(2, s);
        pulse_input(3);
        check("rst_drop_l_state", o_dbg_state, ST_IDLE);
        check("rst_drop_l_dir",   dirRight,    1);
        pulse_input(0);
        pulse_input(1);
        frames(P_DROP, s);
        pulse_input(2);
        frames(2, s);
        pulse_input(3);
        check("rst_drop_r_state", o_dbg_state, ST_IDLE);
        check("rst_drop_r_dir",   dirRight,    1);

`ifdef FLEET_SPEEDUP_EN
        begin
            int first_step;
            int second_step;
            first_step  = -1;
            second_step = -1;
            aliveCount = ALIVE_W'(MAX_INVADERS);
            pulse_input(0);
            aliveCount = ALIVE_W'(1);
            for (int f = 1; f <= 30; f++) begin
                frames(1, s);
                if (s > 0 && first_step < 0)       first_step = f;
                else if (s > 0 && second_step < 0) second_step = f;
            end
            check("speedup_first_step",  first_step,  17);
            check("speedup_second_step", second_step, 21);
            aliveCount = ALIVE_W'(MAX_INVADERS);
        end
`endif

        // Random traffic against the model.
        gap        = 1;
        alive_base = MAX_INVADERS;
        for (int c = 0; c < 20000; c++) begin
            gap--;
            startOfFrame = (gap == 0);
            if (gap == 0) gap = $urandom_range(1, 4);
            reset     = ($urandom_range(0, 2999) == 0);
            pause     = ($urandom_range(0, 15) == 0);
            gameStart = ($urandom_range(0, 79) == 0);
            hitRight  = ($urandom_range(0, 149) == 0);
            hitLeft   = ($urandom_range(0, 149) == 0);
            hitBottom = ($urandom_range(0, 3999) == 0);
            if ($urandom_range(0, 199) == 0) alive_base = $urandom_range(1, MAX_INVADERS);
            aliveCount = ($urandom_range(0, 2999) == 0) ? '0 : ALIVE_W'(alive_base);
            cycle();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
